vga_scanout: RTL and testbench

Next-generation video block. A parametrised raster timing generator with double-buffered (page-flipped) VRAM.
- The CPU writes and reads the back buffer through an SRAM-style port.
- A scanout pipeline reads the front buffer and emits pixels with HSYNC/VSYNC/DE.
- Buffers swap only at vblank start, on CPU request, so the display never tears.

---
 rtl/vga_scanout.sv | 201 ++++++++++++++++++++
 tb/tb_vga_scanout.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator with page-flipped VRAM and a 2-cycle scanout pipeline.
// Optional feature macro: VGA_LINE_IRQ_EN builds the line-compare interrupt; otherwise LINE_IRQ is tied low.
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int DEPTH    = 14,
   parameter int WIDTH    = 32,
   parameter int BPP      = 8
) (
   input  logic                 CLK,
   input  logic                 N_RST,
   input  logic [DEPTH-1:0]     ADDR,
   input  logic                 N_WE,
   input  logic                 N_OE,
   input  logic [WIDTH-1:0]     IN,
   output logic [WIDTH-1:0]     OUT,
   input  logic                 FLIP_REQ,
   output logic                 FLIP_DONE,
   output logic                 FRONT,
   output logic                 VBLANK,
   output logic                 HSYNC,
   output logic                 VSYNC,
   output logic                 DE,
   output logic [BPP-1:0]       PIXEL,
   input  logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] LINE_CMP,
   output logic                 LINE_IRQ
);

   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW         = $clog2(H_TOTAL);
   localparam int VW         = $clog2(V_TOTAL);
   localparam int PPW        = WIDTH / BPP;
   localparam int PPW_LOG2   = $clog2(PPW);
   localparam int LW         = (PPW_LOG2 > 0) ? PPW_LOG2 : 1;
   localparam int IW         = DEPTH + PPW_LOG2;
   localparam int BANK_WORDS = 2 ** DEPTH;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic [VW-1:0]    vcnt_q, vcnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             front_q, front_d;
   logic             pending_q, pending_d;
   logic             flip_done_q, flip_done_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic [WIDTH-1:0] word_q, word_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic             de1_q, de1_d;
   logic             hs1_q, hs1_d;
   logic             vs1_q, vs1_d;

   logic             de_q, de_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic [BPP-1:0]   pixel_q, pixel_d;

   logic             h_end, v_end, active, vblank_start;
   logic             hs_raw, vs_raw;
   logic [DEPTH:0]   scan_addr, cpu_addr;

   // Bank select is the MSB: the scanout always reads FRONT, the CPU always the other bank.
   logic [WIDTH-1:0] vram [2*BANK_WORDS];

   assign h_end        = (hcnt_q == H_LAST);
   assign v_end        = (vcnt_q == V_LAST);
   assign active       = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
   assign vblank_start = (hcnt_q == '0) && (int'(vcnt_q) == V_ACTIVE);
   assign hs_raw       = (int'(hcnt_q) >= H_ACTIVE + H_FP) && (int'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC);
   assign vs_raw       = (int'(vcnt_q) >= V_ACTIVE + V_FP) && (int'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC);
   assign scan_addr    = {front_q, DEPTH'(idx_q >> PPW_LOG2)};
   assign cpu_addr     = {~front_q, ADDR};

   // Raster counters and the linear pixel index.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      idx_d  = idx_q;
      if (h_end) begin
         vcnt_d = v_end ? '0 : vcnt_q + 1'b1;
      end
      if (h_end && v_end) begin
         idx_d = '0;
      end else if (active) begin
         idx_d = idx_q + 1'b1;
      end
   end

   // Page flip: a request is remembered until the next vblank start, then swaps once.
   always_comb begin
      front_d     = front_q;
      pending_d   = pending_q | FLIP_REQ;
      flip_done_d = 1'b0;
      if (vblank_start && (pending_q || FLIP_REQ)) begin
         front_d     = ~front_q;
         pending_d   = 1'b0;
         flip_done_d = 1'b1;
      end
   end

   always_comb begin
      out_d   = N_OE ? '0 : vram[cpu_addr];
      word_d  = vram[scan_addr];
      lane_d  = LW'(idx_q % IW'(PPW));
      de1_d   = active;
      hs1_d   = hs_raw;
      vs1_d   = vs_raw;
      de_d    = de1_q;
      hsync_d = hs1_q ? SYNC_POL : ~SYNC_POL;
      vsync_d = vs1_q ? SYNC_POL : ~SYNC_POL;
      pixel_d = de1_q ? word_q[lane_q*BPP +: BPP] : '0;
   end

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         idx_q       <= '0;
         front_q     <= 1'b0;
         pending_q   <= 1'b0;
         flip_done_q <= 1'b0;
         out_q       <= '0;
         lane_q      <= '0;
         de1_q       <= 1'b0;
         hs1_q       <= 1'b0;
         vs1_q       <= 1'b0;
         de_q        <= 1'b0;
         hsync_q     <= ~SYNC_POL;
         vsync_q     <= ~SYNC_POL;
         pixel_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         idx_q       <= idx_d;
         front_q     <= front_d;
         pending_q   <= pending_d;
         flip_done_q <= flip_done_d;
         out_q       <= out_d;
         lane_q      <= lane_d;
         de1_q       <= de1_d;
         hs1_q       <= hs1_d;
         vs1_q       <= vs1_d;
         de_q        <= de_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         pixel_q     <= pixel_d;
      end
   end

   // NOTE: the VRAM and its read register carry no reset; contents survive N_RST and PIXEL is gated by DE.
   always_ff @(posedge CLK) begin
      if (!N_WE) begin
         vram[cpu_addr] <= IN;
      end
      word_q <= word_d;
   end

`ifdef VGA_LINE_IRQ_EN
   logic line_irq_q, line_irq_d;

   // Compare against the next counter state so the pulse lines up with HCNT == 0.
   assign line_irq_d = (hcnt_d == '0) && (vcnt_d == LINE_CMP);

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         line_irq_q <= 1'b0;
      end else begin
         line_irq_q <= line_irq_d;
      end
   end

   assign LINE_IRQ = line_irq_q;
`else
   logic unused_line_cmp;

   assign unused_line_cmp = ^LINE_CMP;
   assign LINE_IRQ        = 1'b0;
`endif

   assign OUT       = out_q;
   assign FLIP_DONE = flip_done_q;
   assign FRONT     = front_q;
   assign VBLANK    = (int'(vcnt_q) >= V_ACTIVE);
   assign HSYNC     = hsync_q;
   assign VSYNC     = vsync_q;
   assign DE        = de_q;
   assign PIXEL     = pixel_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout with small raster timing and a scoreboard for pixels and CPU reads.
`timescale 1ns/1ps
module tb_vga_scanout;

   localparam int H_ACTIVE = 8;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 2;
   localparam int H_BP     = 2;
   localparam int V_ACTIVE = 4;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 1;
   localparam int V_BP     = 1;
   localparam int H_TOTAL  = 14;
   localparam int V_TOTAL  = 7;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int DEPTH    = 14;
   localparam int WIDTH    = 32;
   localparam int BPP      = 8;
   localparam int PPW      = 4;
   localparam int CW       = 3;

   logic             CLK = 1'b0;
   logic             N_RST = 1'b1;
   logic [DEPTH-1:0] ADDR = '0;
   logic             N_WE = 1'b1;
   logic             N_OE = 1'b1;
   logic [WIDTH-1:0] IN = '0;
   logic             FLIP_REQ = 1'b0;
   logic [CW-1:0]    LINE_CMP = 3'd2;
   logic [WIDTH-1:0] OUT;
   logic             FLIP_DONE, FRONT, VBLANK, HSYNC, VSYNC, DE, LINE_IRQ;
   logic [BPP-1:0]   PIXEL;

   vga_scanout #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(1'b0), .DEPTH(DEPTH), .WIDTH(WIDTH), .BPP(BPP)
   ) dut (
      .CLK(CLK), .N_RST(N_RST), .ADDR(ADDR), .N_WE(N_WE), .N_OE(N_OE), .IN(IN), .OUT(OUT),
      .FLIP_REQ(FLIP_REQ), .FLIP_DONE(FLIP_DONE), .FRONT(FRONT), .VBLANK(VBLANK),
      .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .PIXEL(PIXEL), .LINE_CMP(LINE_CMP), .LINE_IRQ(LINE_IRQ)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        care;
      logic [31:0] val;
   } exp_t;

   exp_t        pix_q[$];
   exp_t        out_q[$];
   logic [31:0] sh    [2][16];
   bit          known [2][16];

   // Reference model state: k = rising edges since reset release.
   int   k = 0;
   bit   front_m, pend_m, done_m;
   int   idx_m, de_cnt;
   int   flip_cnt = 0;
   int   irq_cnt  = 0;
   int   hc, vc, s, hd, vd, w, ln;
   bit   exp_de, exp_hs, exp_vs, exp_irq;
   exp_t e;
   logic [3:0] a;

   always @(negedge CLK) begin
      if (!N_RST) begin
         k = 0; front_m = 0; pend_m = 0; done_m = 0; idx_m = 0; de_cnt = 0;
         pix_q.delete();
         out_q.delete();
         e.care = 1'b1; e.val = 32'h0;
         out_q.push_back(e);
         check("rst_de", DE, 0);
         check("rst_pixel", PIXEL, 0);
         check("rst_out", OUT, 0);
         check("rst_hsync", HSYNC, 1);
         check("rst_vsync", VSYNC, 1);
         check("rst_front", FRONT, 0);
         check("rst_flip_done", FLIP_DONE, 0);
         check("rst_line_irq", LINE_IRQ, 0);
      end else begin
         hc = k % H_TOTAL;
         vc = (k / H_TOTAL) % V_TOTAL;
         if (k >= 2) begin
            s  = k - 2;
            hd = s % H_TOTAL;
            vd = (s / H_TOTAL) % V_TOTAL;
            exp_de = (hd < H_ACTIVE) && (vd < V_ACTIVE);
            exp_hs = !((hd >= H_ACTIVE + H_FP) && (hd < H_ACTIVE + H_FP + H_SYNC));
            exp_vs = !((vd >= V_ACTIVE + V_FP) && (vd < V_ACTIVE + V_FP + V_SYNC));
            if (s % FRAME == 0) de_cnt = 0;
            if (exp_de) de_cnt++;
            if (s % FRAME == FRAME - 1) check("de_per_frame", de_cnt, 32);
         end else begin
            exp_de = 0; exp_hs = 1; exp_vs = 1;
         end
         check("de", DE, exp_de);
         check("hsync", HSYNC, exp_hs);
         check("vsync", VSYNC, exp_vs);
         check("vblank", VBLANK, vc >= V_ACTIVE);
         check("front", FRONT, front_m);
         check("flip_done", FLIP_DONE, done_m);
         if (FLIP_DONE) flip_cnt++;
`ifdef VGA_LINE_IRQ_EN
         exp_irq = (hc == 0) && (vc == int'(LINE_CMP));
`else
         exp_irq = 0;
`endif
         check("line_irq", LINE_IRQ, exp_irq);
         if (LINE_IRQ) irq_cnt++;

         if (exp_de) begin
            check("pix_avail", pix_q.size() != 0, 1);
            if (pix_q.size() != 0) begin
               e = pix_q.pop_front();
               if (e.care) check("pixel", PIXEL, e.val);
            end
         end else begin
            check("pixel_blank", PIXEL, 0);
         end

         check("out_avail", out_q.size() != 0, 1);
         if (out_q.size() != 0) begin
            e = out_q.pop_front();
            if (e.care) check("out", OUT, e.val);
         end

         // Inputs present now are sampled at the next rising edge.
         a = ADDR[3:0];
         if (!N_OE) begin
            e.care = known[!front_m][a]; e.val = sh[!front_m][a];
         end else begin
            e.care = 1'b1; e.val = 32'h0;
         end
         out_q.push_back(e);
         if (!N_WE) begin
            sh[!front_m][a]    = IN;
            known[!front_m][a] = 1'b1;
         end

         if ((hc < H_ACTIVE) && (vc < V_ACTIVE)) begin
            w  = idx_m / PPW;
            ln = idx_m % PPW;
            e.care = (w < 16) ? known[front_m][w[3:0]] : 1'b0;
            e.val  = (w < 16) ? ((sh[front_m][w[3:0]] >> (8 * ln)) & 32'hFF) : 32'h0;
            pix_q.push_back(e);
            idx_m++;
         end
         if ((hc == H_TOTAL - 1) && (vc == V_TOTAL - 1)) idx_m = 0;

         if ((hc == 0) && (vc == V_ACTIVE) && (pend_m || FLIP_REQ)) begin
            front_m = !front_m; pend_m = 0; done_m = 1;
         end else begin
            pend_m = pend_m || FLIP_REQ; done_m = 0;
         end
         k++;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cpu_write(input int addr, input logic [31:0] data);
      ADDR = DEPTH'(addr); IN = data; N_WE = 1'b0;
      tick();
      N_WE = 1'b1;
   endtask

   task automatic pulse_flip();
      FLIP_REQ = 1'b1;
      tick();
      FLIP_REQ = 1'b0;
   endtask

   task automatic wait_flip_done();
      bit seen = 0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         tick();
         if (FLIP_DONE) seen = 1;
      end
      check("flip_done_seen", seen, 1);
   endtask

   task automatic wait_frame_start();
      bit hi = 0;
      bit seen = 0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         tick();
         if (VBLANK) hi = 1;
         else if (hi) seen = 1;
      end
      check("frame_start_seen", seen, 1);
   endtask

   logic [31:0] b1 [8];
   logic [7:0]  first_px [4];
   int          fc, ic;
   bit          de_seen;

   initial begin
      first_px[0] = 8'h11; first_px[1] = 8'h22; first_px[2] = 8'h33; first_px[3] = 8'h44;
      #2 N_RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1 N_RST = 1'b1;

      // Raster timing over two frames with the monitor checking every cycle.
      repeat (2 * FRAME) tick();

      // Fill back bank 1, then flip it to the front.
      for (int i = 0; i < 8; i++) begin
         b1[i] = (i == 0) ? 32'h44332211 : $urandom;
         cpu_write(i, b1[i]);
      end
      pulse_flip();
      wait_flip_done();
      check("front_after_flip", FRONT, 1);
      de_seen = 0;
      for (int i = 0; i < 2 * FRAME && !de_seen; i++) begin
         tick();
         if (DE) de_seen = 1;
      end
      check("de_seen", de_seen, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("first_px%0d", i), PIXEL, first_px[i]);
         tick();
      end

      // Back bank is now bank 0: write, read back, read with N_OE high.
      for (int i = 0; i < 8; i++) cpu_write(i, (i == 5) ? 32'hDEADBEEF : $urandom);
      ADDR = 14'd5; N_OE = 1'b0;
      tick();
      N_OE = 1'b1;
      check("rd_back5", OUT, 32'hDEADBEEF);
      tick();
      check("rd_oe_high", OUT, 32'h0);
      pulse_flip();
      wait_flip_done();
      check("front_after_flip2", FRONT, 0);
      ADDR = 14'd5; N_OE = 1'b0;
      tick();
      N_OE = 1'b1;
      check("rd_other5", OUT, b1[5]);

      // Three requests within one frame collapse into one swap.
      wait_frame_start();
      fc = flip_cnt;
      for (int i = 0; i < 3; i++) begin
         pulse_flip();
         tick();
         tick();
      end
      repeat (FRAME) tick();
      check("flip_once", flip_cnt - fc, 1);
      check("front_toggled", FRONT, 1);

      // Reset mid-line with a flip pending and a read in flight.
      wait_frame_start();
      pulse_flip();
      ADDR = 14'd5; N_OE = 1'b0;
      tick();
      tick();
      @(posedge CLK);
      #2 N_RST = 1'b0;
      #1;
      check("mid_rst_de", DE, 0);
      check("mid_rst_pixel", PIXEL, 0);
      check("mid_rst_out", OUT, 0);
      check("mid_rst_front", FRONT, 0);
      check("mid_rst_flip_done", FLIP_DONE, 0);
      check("mid_rst_hsync", HSYNC, 1);
      check("mid_rst_vsync", VSYNC, 1);
      check("mid_rst_vblank", VBLANK, 0);
      check("mid_rst_line_irq", LINE_IRQ, 0);
      N_OE = 1'b1;
      tick();
      tick();
      N_RST = 1'b1;
      fc = flip_cnt;
      repeat (2 * FRAME) tick();
      check("no_flip_after_rst", flip_cnt - fc, 0);
      check("front_after_rst", FRONT, 0);

      // Line interrupt count over two frames.
      ic = irq_cnt;
      repeat (2 * FRAME) tick();
`ifdef VGA_LINE_IRQ_EN
      check("line_irq_count", irq_cnt - ic, 2);
`else
      check("line_irq_count", irq_cnt - ic, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
